load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the core's execute stage and data_memory.
- Accepts one load or store request at a time and handles byte, halfword and word sizes, with sign or zero extension on loads.
- Sub-word stores are done as read-modify-write, because data_memory only writes full 32-bit words.
- Drives data_memory's read flag, write flag, address and write-data inputs, takes its read data back, and returns a registered response to the core.

Parameters:
- MEM_WORDS, 32, number of 32-bit words behind the unit. A word index of MEM_WORDS or above is an access error.
- ADDR_W, 32, width of the byte address.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-low; clears all state immediately.
- req_valid  input  1  core presents a request.
- req_ready  output  1  unit can accept a request. High only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 = byte, 01 = halfword, 10 = word; 11 is illegal.
- req_unsigned  input  1  loads only: zero-extend when 1, sign-extend when 0.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  one-cycle pulse; the request has completed.
- resp_rdata  output  32  extended load data. 0 for stores and errors.
- resp_err  output  1  misaligned access, out-of-range address or illegal size. Valid with resp_valid.
- data_read_flag  output  1  to data_memory read flag.
- data_write_flag  output  1  to data_memory write flag.
- data_addr  output  32  to data_memory; word-aligned, bits [1:0] = 00.
- val  output  32  to data_memory write data.
- read_out  input  32  from data_memory; combinational read data.

Behaviour:
- Reset (rst=0): state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; data_read_flag=0; data_write_flag=0; data_addr=0; val=0.
- Reset is asynchronous and may arrive in any state. It aborts the operation in flight: no write is issued and no response is produced.
- A request is accepted when req_valid=1 and req_ready=1. Address, size, data and flags are latched on that edge.
- Error check, done at acceptance:
  - halfword with addr[0]=1 is misaligned;
  - word with addr[1:0]≠00 is misaligned;
  - size=11 is illegal;
  - addr[ADDR_W-1:2] ≥ MEM_WORDS is out of range.
- Outputs to data_memory are driven from registered request fields. data_read_flag and data_write_flag are never both 1.
- States:
  - IDLE: req_ready=1, memory flags 0.
    - Legal load → LOAD.
    - Legal word store → WRITE, with val = wdata.
    - Legal sub-word store → RMW_RD.
    - Any error → RESP, with err=1.
  - LOAD: data_read_flag=1. Extract the lane from read_out using addr[1:0] and size, then extend. The result is registered at the end of the cycle → RESP.
  - RMW_RD: data_read_flag=1. Capture read_out into the merge register, overwriting only the byte or halfword lane selected by addr[1:0] with wdata[7:0] or wdata[15:0] → WRITE.
  - WRITE: data_write_flag=1, val = merge register (or wdata for a word store). The memory writes on this cycle's closing edge → RESP.
  - RESP: resp_valid=1 for exactly one cycle, with resp_rdata and resp_err → IDLE.
- Latencies, counted from the acceptance edge to resp_valid:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 1 cycle.
- A new request can be accepted on the cycle after RESP, when the unit is back in IDLE.
- Lane selection:
  - byte lane n covers bits [8n+7:8n], with n = addr[1:0];
  - halfword lane is bits [15:0] when addr[1]=0, else bits [31:16].
- An error never touches memory: both flags stay 0 for the whole request.
- req_valid held high while req_ready=0 is ignored. The request must be held stable until it is accepted.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: misaligned halfword or word accesses produce resp_err=1 with no memory access, as described in Behaviour.
- Undefined: the misalignment check is removed.
  - The address is forced aligned: addr[0] is cleared for halfwords, addr[1:0] for words.
  - The access then proceeds normally.
  - Illegal size and out-of-range errors still apply.

Test Plan:
- After reset (memory word0=0x0000000F), load word at 0x0 → resp_valid on the 2nd cycle after acceptance, resp_rdata=0x0000000F, resp_err=0.
- Store byte 0xAB at 0x9 (word2=0) → data_write_flag high one cycle with val=0x0000AB00 to address 0x8, resp 3 cycles after acceptance.
- Then load byte at 0x9 with req_unsigned=0 → 0xFFFFFFAB; with req_unsigned=1 → 0x000000AB. Load halfword at 0x8 with req_unsigned=0 → 0xFFFFAB00.
- Load halfword at 0x3 → with LSU_MISALIGN_TRAP_EN: resp_err=1 one cycle after acceptance, both memory flags 0 throughout. Without the macro: reads the halfword at 0x2.
- Store word at 0x80 (word index 32 ≥ MEM_WORDS) → resp_err=1, no write; req_size=11 → resp_err=1.
- Assert rst=0 while in WRITE for a byte store → no write occurs, resp_valid=0, req_ready=1 immediately; the memory word keeps its old value.

Source files
------------

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Byte/halfword/word load-store engine in front of a word-only
//            data memory. Sub-word stores are done as read-modify-write.
//            Optional: LSU_MISALIGN_TRAP_EN turns misaligned accesses into errors.
// Revision : 1.0
// ============================================================================
module load_store_unit #(
  parameter int MEM_WORDS = 32,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              data_read_flag,
  output logic              data_write_flag,
  output logic [31:0]       data_addr,
  output logic [31:0]       val,
  input  logic [31:0]       read_out
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t      state;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [1:0]  offset_q;
  logic [15:0] wdata_q;

  logic [ADDR_W-1:0] addr_eff;
  logic              misaligned;
  logic              req_err;
  logic [31:0]       word_addr;
  logic [7:0]        lane_byte;
  logic [15:0]       lane_half;
  logic [31:0]       load_ext;
  logic [31:0]       merged;

  always_comb begin
    addr_eff   = req_addr;
    misaligned = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                 ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    // Without trapping, misaligned accesses are silently rounded down.
    if (req_size == 2'b01)
      addr_eff[0] = 1'b0;
    else if (req_size == 2'b10)
      addr_eff[1:0] = 2'b00;
`endif
    req_err   = misaligned || (req_size == 2'b11) ||
                ((req_addr >> 2) >= ADDR_W'(MEM_WORDS));
    word_addr = 32'({addr_eff[ADDR_W-1:2], 2'b00});
  end

  always_comb begin
    lane_byte = read_out[{offset_q, 3'b000} +: 8];
    lane_half = offset_q[1] ? read_out[31:16] : read_out[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{~unsigned_q & lane_byte[7]}}, lane_byte};
      2'b01:   load_ext = {{16{~unsigned_q & lane_half[15]}}, lane_half};
      default: load_ext = read_out;
    endcase
    merged = read_out;
    if (size_q == 2'b00)
      merged[{offset_q, 3'b000} +: 8] = wdata_q[7:0];
    else
      merged[{offset_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      req_ready       <= 1'b1;
      resp_valid      <= 1'b0;
      resp_rdata      <= 32'd0;
      resp_err        <= 1'b0;
      data_read_flag  <= 1'b0;
      data_write_flag <= 1'b0;
      data_addr       <= 32'd0;
      val             <= 32'd0;
      size_q          <= 2'b00;
      unsigned_q      <= 1'b0;
      offset_q        <= 2'b00;
      wdata_q         <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready  <= 1'b0;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            offset_q   <= addr_eff[1:0];
            wdata_q    <= req_wdata[15:0];
            if (req_err) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
              state      <= RESP;
            end else begin
              data_addr <= word_addr;
              if (!req_we) begin
                data_read_flag <= 1'b1;
                state          <= LOAD;
              end else if (req_size == 2'b10) begin
                val             <= req_wdata;
                data_write_flag <= 1'b1;
                state           <= WRITE;
              end else begin
                data_read_flag <= 1'b1;
                state          <= RMW_RD;
              end
            end
          end
        end
        LOAD: begin
          data_read_flag <= 1'b0;
          resp_rdata     <= load_ext;
          resp_err       <= 1'b0;
          resp_valid     <= 1'b1;
          state          <= RESP;
        end
        RMW_RD: begin
          // val doubles as the merge register for the write that follows.
          data_read_flag  <= 1'b0;
          val             <= merged;
          data_write_flag <= 1'b1;
          state           <= WRITE;
        end
        WRITE: begin
          data_write_flag <= 1'b0;
          resp_rdata      <= 32'd0;
          resp_err        <= 1'b0;
          resp_valid      <= 1'b1;
          state           <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          data_read_flag  <= 1'b0;
          data_write_flag <= 1'b0;
          resp_valid      <= 1'b0;
          req_ready       <= 1'b1;
          state           <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Directed bench for load_store_unit with a word-wide memory model.
// Revision : 1.0
// ============================================================================
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        data_read_flag;
  logic        data_write_flag;
  logic [31:0] data_addr;
  logic [31:0] val;
  logic [31:0] read_out;

  load_store_unit #(.MEM_WORDS(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .data_read_flag(data_read_flag),
    .data_write_flag(data_write_flag), .data_addr(data_addr), .val(val),
    .read_out(read_out)
  );

  always #5 clk = ~clk;

  // Word-only memory model with combinational read.
  logic [31:0] mem [0:31];
  logic        mem_init = 1'b1;
  logic        addr_in_range;
  assign addr_in_range = (data_addr[31:7] == 25'd0);
  assign read_out = addr_in_range ? mem[data_addr[6:2]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
      mem[0] <= 32'h0000_000F;
    end else if (data_write_flag && addr_in_range) begin
      mem[data_addr[6:2]] <= val;
    end
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  int          lat;
  int          wr_cnt;
  int          rd_cnt;
  int          both_cnt = 0;
  logic [31:0] got_rdata;
  logic        got_err;
  logic [31:0] wr_val;
  logic [31:0] wr_addr;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request and watch the memory interface until resp_valid.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_value("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size;
    req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 99; wr_cnt = 0; rd_cnt = 0; wr_val = 32'd0; wr_addr = 32'd0;
    got_rdata = 32'hx; got_err = 1'bx;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (data_write_flag) begin
        wr_cnt++; wr_val = val; wr_addr = data_addr;
      end
      if (data_read_flag) rd_cnt++;
      if (data_write_flag && data_read_flag) both_cnt++;
      if (resp_valid) begin
        lat = i; got_rdata = resp_rdata; got_err = resp_err;
        break;
      end
    end
  endtask

  task automatic expect_resp(input string tag, input int e_lat, input logic [31:0] e_rdata,
                             input logic e_err, input int e_wr);
    check_value({tag, " latency"}, 32'(lat), 32'(e_lat));
    check_value({tag, " rdata"}, got_rdata, e_rdata);
    check_value({tag, " err"}, 32'(got_err), 32'(e_err));
    check_value({tag, " writes"}, 32'(wr_cnt), 32'(e_wr));
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_value("reset req_ready", 32'(req_ready), 32'd1);
    check_value("reset resp_valid", 32'(resp_valid), 32'd0);
    check_value("reset resp_rdata", resp_rdata, 32'd0);
    check_value("reset resp_err", 32'(resp_err), 32'd0);
    check_value("reset flags", {30'd0, data_read_flag, data_write_flag}, 32'd0);
    check_value("reset data_addr", data_addr, 32'd0);
    check_value("reset val", val, 32'd0);
    mem_init = 1'b0;
    rst = 1'b1;

    do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    expect_resp("ld_w_0", 2, 32'h0000_000F, 1'b0, 0);

    do_req(1'b1, 2'b00, 1'b0, 32'h9, 32'h0000_00AB);
    expect_resp("st_b_9", 3, 32'h0, 1'b0, 1);
    check_value("st_b_9 val", wr_val, 32'h0000_AB00);
    check_value("st_b_9 addr", wr_addr, 32'h0000_0008);

    do_req(1'b0, 2'b00, 1'b0, 32'h9, 32'h0);
    expect_resp("ld_b_9_s", 2, 32'hFFFF_FFAB, 1'b0, 0);
    do_req(1'b0, 2'b00, 1'b1, 32'h9, 32'h0);
    expect_resp("ld_b_9_u", 2, 32'h0000_00AB, 1'b0, 0);
    do_req(1'b0, 2'b01, 1'b0, 32'h8, 32'h0);
    expect_resp("ld_h_8_s", 2, 32'hFFFF_AB00, 1'b0, 0);

    do_req(1'b1, 2'b10, 1'b0, 32'h4, 32'h1234_5678);
    expect_resp("st_w_4", 2, 32'h0, 1'b0, 1);
    check_value("st_w_4 val", wr_val, 32'h1234_5678);
    check_value("st_w_4 addr", wr_addr, 32'h0000_0004);
    do_req(1'b0, 2'b01, 1'b1, 32'h6, 32'h0);
    expect_resp("ld_h_6_u", 2, 32'h0000_1234, 1'b0, 0);
    do_req(1'b0, 2'b00, 1'b0, 32'h4, 32'h0);
    expect_resp("ld_b_4_s", 2, 32'h0000_0078, 1'b0, 0);
    do_req(1'b1, 2'b01, 1'b0, 32'h6, 32'h0000_BEEF);
    expect_resp("st_h_6", 3, 32'h0, 1'b0, 1);
    check_value("st_h_6 val", wr_val, 32'hBEEF_5678);
    do_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    expect_resp("ld_w_4", 2, 32'hBEEF_5678, 1'b0, 0);
    do_req(1'b0, 2'b01, 1'b0, 32'h6, 32'h0);
    expect_resp("ld_h_6_s", 2, 32'hFFFF_BEEF, 1'b0, 0);

`ifdef LSU_MISALIGN_TRAP_EN
    do_req(1'b0, 2'b01, 1'b0, 32'h3, 32'h0);
    expect_resp("ld_h_3_trap", 1, 32'h0, 1'b1, 0);
    check_value("ld_h_3_trap reads", 32'(rd_cnt), 32'd0);
    do_req(1'b0, 2'b10, 1'b0, 32'h5, 32'h0);
    expect_resp("ld_w_5_trap", 1, 32'h0, 1'b1, 0);
    check_value("ld_w_5_trap reads", 32'(rd_cnt), 32'd0);
`else
    do_req(1'b0, 2'b01, 1'b0, 32'h3, 32'h0);
    expect_resp("ld_h_3_align", 2, 32'h0000_0000, 1'b0, 0);
    do_req(1'b0, 2'b01, 1'b0, 32'h7, 32'h0);
    expect_resp("ld_h_7_align", 2, 32'hFFFF_BEEF, 1'b0, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h5, 32'h0);
    expect_resp("ld_w_5_align", 2, 32'hBEEF_5678, 1'b0, 0);
`endif

    do_req(1'b1, 2'b10, 1'b0, 32'h80, 32'hCAFE_F00D);
    expect_resp("st_w_80_range", 1, 32'h0, 1'b1, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h7C, 32'h0);
    expect_resp("ld_w_7c_last", 2, 32'h0, 1'b0, 0);
    do_req(1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
    expect_resp("ld_size11", 1, 32'h0, 1'b1, 0);
    check_value("ld_size11 reads", 32'(rd_cnt), 32'd0);

    // Abort a byte store while it sits in WRITE.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'hA; req_wdata = 32'h0000_00CD;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_value("abort in WRITE", 32'(data_write_flag), 32'd1);
    check_value("abort val", val, 32'h00CD_AB00);
    rst = 1'b0;
    #1;
    check_value("abort write_flag", 32'(data_write_flag), 32'd0);
    check_value("abort req_ready", 32'(req_ready), 32'd1);
    check_value("abort resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    check_value("abort mem kept", mem[2], 32'h0000_AB00);
    do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    expect_resp("ld_w_8_after_abort", 2, 32'h0000_AB00, 1'b0, 0);

    check_value("flags exclusive", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
